// File: rtl/dvp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dvp_pkg                                                         |
// | Brief    : Shared states, pattern selectors and colour-bar tables for the  |
// |            DVP frame generator.                                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dvp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_VSYNC  = 3'd1;
    localparam state_t c_ST_VBACK  = 3'd2;
    localparam state_t c_ST_ACTIVE = 3'd3;
    localparam state_t c_ST_HBLANK = 3'd4;
    localparam state_t c_ST_VFRONT = 3'd5;

    localparam logic [1:0] c_PAT_COUNTER = 2'd0;
    localparam logic [1:0] c_PAT_BARS    = 2'd1;
    localparam logic [1:0] c_PAT_RAMP    = 2'd2;

    // Index 0 is the leftmost bar (rightmost element of the concatenation).
    localparam logic [7:0][15:0] c_BAR_RGB565 = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };
    localparam logic [7:0][7:0] c_BAR_GRAY = {
        8'h00, 8'h20, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'hFF
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pattern_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dvp_pattern_rom                                                 |
// | Brief    : Combinational pixel-byte source: counter, colour bars or ramp.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dvp_pattern_rom
    import dvp_pkg::*;
#(
    parameter int IM_X       = 1280,
    parameter int COLOR_MODE = 2,
    parameter int X_W        = 12,
    parameter int B_W        = 1
) (
    input  logic [1:0]     i_pattern,
    input  logic [X_W-1:0] i_x,
    input  logic [B_W-1:0] i_b,
    input  logic [7:0]     i_counter,
    output logic [7:0]     o_data
);

    localparam int unsigned c_BAR_W = (IM_X >= 8) ? IM_X / 8 : 1;
    localparam bit          c_GRAY  = (COLOR_MODE == 1);

    logic [31:0] w_x_ext;
    logic [31:0] w_bar_raw;
    logic [2:0]  w_bar;
    logic [7:0]  w_v;
    logic [15:0] w_ramp565;
    logic [15:0] w_bar565;

    always_comb begin
        w_x_ext   = 32'(i_x);
        w_bar_raw = w_x_ext / c_BAR_W;
        // Pixels past the eighth full bar (IM_X not a multiple of 8) stay in bar 7.
        w_bar     = (w_bar_raw > 32'd7) ? 3'd7 : w_bar_raw[2:0];
        w_v       = w_x_ext[7:0];
        w_ramp565 = {w_v[7:3], w_v[7:2], w_v[7:3]};
        w_bar565  = c_BAR_RGB565[w_bar];
        o_data    = i_counter;
        case (i_pattern)
            c_PAT_BARS: o_data = c_GRAY ? c_BAR_GRAY[w_bar]
                               : ((i_b == '0) ? w_bar565[15:8] : w_bar565[7:0]);
            c_PAT_RAMP: o_data = c_GRAY ? w_v
                               : ((i_b == '0) ? w_ramp565[15:8] : w_ramp565[7:0]);
            default:    o_data = i_counter;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dvp_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dvp_frame_gen                                                   |
// | Brief    : Camera-side DVP transmitter producing PCLK/VSYNC/HREF/data.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dvp_frame_gen
    import dvp_pkg::*;
#(
    parameter int IM_X       = 1280,
    parameter int IM_Y       = 720,
    parameter int COLOR_MODE = 2,
    parameter int H_BLANK    = 64,
    parameter int VS_LEN     = 16,
    parameter int V_BACK     = 32,
    parameter int V_FRONT    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic        PCLK_cam,
    output logic        VSYNC_cam,
    output logic        HREF_cam,
    output logic [7:0]  data_cam,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int c_CNT_MAX = max2(max2(VS_LEN, V_BACK), max2(H_BLANK, V_FRONT));
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
    localparam int c_X_W     = $clog2(IM_X) + 1;
    localparam int c_Y_W     = $clog2(IM_Y) + 1;
    localparam int c_B_W     = (COLOR_MODE > 1) ? $clog2(COLOR_MODE) : 1;

    localparam logic [c_CNT_W-1:0] c_VS_LAST = c_CNT_W'(VS_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_VB_LAST = c_CNT_W'(V_BACK - 1);
    localparam logic [c_CNT_W-1:0] c_HB_LAST = c_CNT_W'(H_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_VF_LAST = c_CNT_W'(V_FRONT - 1);
    localparam logic [c_X_W-1:0]   c_X_LAST  = c_X_W'(IM_X - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST  = c_Y_W'(IM_Y - 1);
    localparam logic [c_B_W-1:0]   c_B_LAST  = c_B_W'(COLOR_MODE - 1);

    state_t             r_state,      w_state_nxt;
    logic               r_pclk,       w_pclk_nxt;
    logic [c_CNT_W-1:0] r_cnt,        w_cnt_nxt;
    logic [c_X_W-1:0]   r_x,          w_x_nxt;
    logic [c_Y_W-1:0]   r_y,          w_y_nxt;
    logic [c_B_W-1:0]   r_b,          w_b_nxt;
    logic [7:0]         r_byte_cnt,   w_byte_cnt_nxt;
    logic [1:0]         r_pat,        w_pat_nxt;
    logic               r_vsync,      w_vsync_nxt;
    logic               r_href,       w_href_nxt;
    logic [7:0]         r_data,       w_data_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic [15:0]        r_frame_cnt,  w_frame_cnt_nxt;
    logic               w_tick;
    logic [7:0]         w_rom_byte;

    dvp_pattern_rom #(
        .IM_X       (IM_X),
        .COLOR_MODE (COLOR_MODE),
        .X_W        (c_X_W),
        .B_W        (c_B_W)
    ) u_rom (
        .i_pattern  (r_pat),
        .i_x        (r_x),
        .i_b        (r_b),
        .i_counter  (r_byte_cnt),
        .o_data     (w_rom_byte)
    );

    // PCLK is high during a tick, so line outputs move together with its falling edge.
    assign w_tick = r_pclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_pclk       <= 1'b0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_b          <= '0;
            r_byte_cnt   <= '0;
            r_pat        <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pclk       <= w_pclk_nxt;
            r_cnt        <= w_cnt_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_b          <= w_b_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_pat        <= w_pat_nxt;
            r_vsync      <= w_vsync_nxt;
            r_href       <= w_href_nxt;
            r_data       <= w_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pclk_nxt       = (r_state == c_ST_IDLE) ? 1'b0 : ~r_pclk;
        w_cnt_nxt        = r_cnt;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_b_nxt          = r_b;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_pat_nxt        = r_pat;
        w_vsync_nxt      = r_vsync;
        w_href_nxt       = r_href;
        w_data_nxt       = r_data;
        w_frame_done_nxt = 1'b0;
        w_frame_cnt_nxt  = r_frame_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_state_nxt    = c_ST_VSYNC;
                    w_pat_nxt      = pattern;
                    w_cnt_nxt      = '0;
                    w_byte_cnt_nxt = '0;
                end
            end
            c_ST_VSYNC: begin
                if (w_tick) begin
                    w_vsync_nxt = 1'b1;
                    w_href_nxt  = 1'b0;
                    w_data_nxt  = '0;
                    if (r_cnt == c_VS_LAST) begin
                        w_state_nxt = c_ST_VBACK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            c_ST_VBACK: begin
                if (w_tick) begin
                    w_vsync_nxt = 1'b0;
                    w_href_nxt  = 1'b0;
                    w_data_nxt  = '0;
                    if (r_cnt == c_VB_LAST) begin
                        w_state_nxt = c_ST_ACTIVE;
                        w_cnt_nxt   = '0;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_b_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            c_ST_ACTIVE: begin
                if (w_tick) begin
                    w_href_nxt     = 1'b1;
                    w_data_nxt     = w_rom_byte;
                    w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                    if (r_b == c_B_LAST) begin
                        w_b_nxt = '0;
                        if (r_x == c_X_LAST) begin
                            w_x_nxt     = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_HBLANK;
                        end else begin
                            w_x_nxt = r_x + c_X_W'(1);
                        end
                    end else begin
                        w_b_nxt = r_b + c_B_W'(1);
                    end
                end
            end
            c_ST_HBLANK: begin
                if (w_tick) begin
                    w_href_nxt = 1'b0;
                    w_data_nxt = '0;
                    if (r_cnt == c_HB_LAST) begin
                        w_y_nxt     = r_y + c_Y_W'(1);
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_y == c_Y_LAST) ? c_ST_VFRONT : c_ST_ACTIVE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            c_ST_VFRONT: begin
                if (w_tick) begin
                    w_href_nxt = 1'b0;
                    w_data_nxt = '0;
                    if (r_cnt == c_VF_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
                        w_cnt_nxt        = '0;
                        // PCLK falls on this same edge, so a return to IDLE parks it at 0.
                        if (enable) begin
                            w_state_nxt    = c_ST_VSYNC;
                            w_pat_nxt      = pattern;
                            w_byte_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign PCLK_cam   = r_pclk;
    assign VSYNC_cam  = r_vsync;
    assign HREF_cam   = r_href;
    assign data_cam   = r_data;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dvp_frame_gen                                                |
// | Brief    : Directed bench: three generator geometries, vector table plus   |
// |            enable-drop and mid-frame reset sequences.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dvp_frame_gen;

    localparam int c_MEM = 4096;

    typedef struct {
        int         inst;
        logic [1:0] pat;
        int         idx;
        logic [7:0] want;
    } vec_t;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_v [3];
    logic        en_v   [3];
    logic [1:0]  pat_v  [3];
    logic        pclk_v [3];
    logic        vs_v   [3];
    logic        hr_v   [3];
    logic [7:0]  data_v [3];
    logic        fd_v   [3];
    logic [15:0] fcnt_v [3];

    // Instance 0: tiny gray frame; 1: 8-pixel RGB565; 2: 300-pixel gray line.
    dvp_frame_gen #(.IM_X(4), .IM_Y(2), .COLOR_MODE(1), .H_BLANK(2),
                    .VS_LEN(3), .V_BACK(2), .V_FRONT(2)) u_a (
        .clk(clk), .rst_n(rstn_v[0]), .enable(en_v[0]), .pattern(pat_v[0]),
        .PCLK_cam(pclk_v[0]), .VSYNC_cam(vs_v[0]), .HREF_cam(hr_v[0]),
        .data_cam(data_v[0]), .frame_done(fd_v[0]), .frame_cnt(fcnt_v[0]));
    dvp_frame_gen #(.IM_X(8), .IM_Y(2), .COLOR_MODE(2), .H_BLANK(2),
                    .VS_LEN(3), .V_BACK(2), .V_FRONT(2)) u_b (
        .clk(clk), .rst_n(rstn_v[1]), .enable(en_v[1]), .pattern(pat_v[1]),
        .PCLK_cam(pclk_v[1]), .VSYNC_cam(vs_v[1]), .HREF_cam(hr_v[1]),
        .data_cam(data_v[1]), .frame_done(fd_v[1]), .frame_cnt(fcnt_v[1]));
    dvp_frame_gen #(.IM_X(300), .IM_Y(1), .COLOR_MODE(1), .H_BLANK(2),
                    .VS_LEN(3), .V_BACK(2), .V_FRONT(2)) u_c (
        .clk(clk), .rst_n(rstn_v[2]), .enable(en_v[2]), .pattern(pat_v[2]),
        .PCLK_cam(pclk_v[2]), .VSYNC_cam(vs_v[2]), .HREF_cam(hr_v[2]),
        .data_cam(data_v[2]), .frame_done(fd_v[2]), .frame_cnt(fcnt_v[2]));

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         nbytes [3];
    int         rises [3];
    int         vs_ticks [3];
    int         dones [3];
    int         viol [3];
    int         run [3];
    int         last_run [3];
    int         last_done_cyc [3];
    bit         prev_pclk [3];
    bit [9:0]   prev_out [3];
    logic [7:0] mem [3][c_MEM];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: one negedge per PCLK high phase captures the receiver's view.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pclk_v[i] && !prev_pclk[i] && ({vs_v[i], hr_v[i], data_v[i]} != prev_out[i]))
                viol[i] <= viol[i] + 1;
            if (pclk_v[i]) begin
                rises[i] <= rises[i] + 1;
                if (vs_v[i]) vs_ticks[i] <= vs_ticks[i] + 1;
                if (hr_v[i]) begin
                    mem[i][12'(nbytes[i])] <= data_v[i];
                    nbytes[i] <= nbytes[i] + 1;
                    run[i] <= run[i] + 1;
                end else if (run[i] != 0) begin
                    last_run[i] <= run[i];
                    run[i] <= 0;
                end
            end
            if (fd_v[i]) begin
                dones[i] <= dones[i] + 1;
                last_done_cyc[i] <= cyc;
            end
            prev_pclk[i] <= pclk_v[i];
            prev_out[i]  <= {vs_v[i], hr_v[i], data_v[i]};
        end
    end

    function automatic int exp_bytes(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 32 : 300);
    endfunction

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int i, input int target, input string nm);
        int n;
        n = 0;
        while (dones[i] < target && n < 4000) begin
            tick(1);
            n++;
        end
        chk({nm, "_reached"}, (dones[i] >= target) ? 1 : 0, 1);
    endtask

    // Enable is held only until PCLK starts, so each call yields exactly one frame.
    task automatic run_frame(input int i, input logic [1:0] p, output int base);
        int r0, d0, n;
        base = nbytes[i];
        r0   = rises[i];
        d0   = dones[i];
        pat_v[i] = p;
        en_v[i]  = 1'b1;
        n = 0;
        while (rises[i] == r0 && n < 20) begin
            tick(1);
            n++;
        end
        en_v[i] = 1'b0;
        wait_done(i, d0 + 1, $sformatf("frame_i%0d_p%0d", i, p));
        tick(4);
        chk($sformatf("bytes_i%0d_p%0d", i, p), nbytes[i] - base, exp_bytes(i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [36];
        int         base, cur_i, d0, r0, v0, n, t1, t2, t3;
        logic [1:0] cur_p;

        vecs[0]  = '{0, 2'd0, 0,   8'h00};
        vecs[1]  = '{0, 2'd0, 3,   8'h03};
        vecs[2]  = '{0, 2'd0, 4,   8'h04};
        vecs[3]  = '{0, 2'd0, 7,   8'h07};
        vecs[4]  = '{0, 2'd1, 0,   8'hFF};
        vecs[5]  = '{0, 2'd1, 1,   8'hE0};
        vecs[6]  = '{0, 2'd1, 3,   8'hA0};
        vecs[7]  = '{0, 2'd1, 5,   8'hE0};
        vecs[8]  = '{0, 2'd2, 2,   8'h02};
        vecs[9]  = '{0, 2'd2, 6,   8'h02};
        vecs[10] = '{0, 2'd3, 5,   8'h05};
        vecs[11] = '{1, 2'd1, 0,   8'hFF};
        vecs[12] = '{1, 2'd1, 1,   8'hFF};
        vecs[13] = '{1, 2'd1, 3,   8'hE0};
        vecs[14] = '{1, 2'd1, 4,   8'h07};
        vecs[15] = '{1, 2'd1, 5,   8'hFF};
        vecs[16] = '{1, 2'd1, 8,   8'hF8};
        vecs[17] = '{1, 2'd1, 9,   8'h1F};
        vecs[18] = '{1, 2'd1, 11,  8'h00};
        vecs[19] = '{1, 2'd1, 13,  8'h1F};
        vecs[20] = '{1, 2'd1, 14,  8'h00};
        vecs[21] = '{1, 2'd1, 18,  8'hFF};
        vecs[22] = '{1, 2'd1, 19,  8'hE0};
        vecs[23] = '{1, 2'd2, 8,   8'h00};
        vecs[24] = '{1, 2'd2, 9,   8'h20};
        vecs[25] = '{1, 2'd2, 15,  8'h20};
        vecs[26] = '{2, 2'd2, 128, 8'h80};
        vecs[27] = '{2, 2'd2, 255, 8'hFF};
        vecs[28] = '{2, 2'd2, 256, 8'h00};
        vecs[29] = '{2, 2'd2, 299, 8'h2B};
        vecs[30] = '{2, 2'd1, 36,  8'hFF};
        vecs[31] = '{2, 2'd1, 37,  8'hE0};
        vecs[32] = '{2, 2'd1, 258, 8'h20};
        vecs[33] = '{2, 2'd1, 259, 8'h00};
        vecs[34] = '{2, 2'd0, 255, 8'hFF};
        vecs[35] = '{2, 2'd0, 256, 8'h00};

        for (int i = 0; i < 3; i++) begin
            rstn_v[i] = 1'b0;
            en_v[i]   = 1'b0;
            pat_v[i]  = 2'd0;
        end
        tick(3);
        chk("reset_outputs", {pclk_v[0], vs_v[0], hr_v[0], data_v[0], fd_v[0]}, 0);
        chk("reset_frame_cnt", fcnt_v[0], 0);
        for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;
        tick(2);

        // Back-to-back frames with enable held high.
        d0 = dones[0];
        base = nbytes[0];
        v0 = vs_ticks[0];
        pat_v[0] = 2'd0;
        en_v[0]  = 1'b1;
        wait_done(0, d0 + 1, "t1_done1");
        t1 = last_done_cyc[0];
        chk("t1_frame_cnt1", fcnt_v[0], 1);
        wait_done(0, d0 + 2, "t1_done2");
        t2 = last_done_cyc[0];
        chk("t1_frame_cnt2", fcnt_v[0], 2);
        en_v[0] = 1'b0;
        wait_done(0, d0 + 3, "t1_done3");
        t3 = last_done_cyc[0];
        chk("t1_frame_cnt3", fcnt_v[0], 3);
        chk("t1_period_1_2", t2 - t1, 38);
        chk("t1_period_2_3", t3 - t2, 38);
        chk("t1_vsync_pclks", vs_ticks[0] - v0, 9);
        chk("t1_total_bytes", nbytes[0] - base, 24);
        chk("t1_f1_last_byte", mem[0][12'(base + 7)], 8'h07);
        chk("t1_f2_first_byte", mem[0][12'(base + 8)], 8'h00);
        tick(4);

        // Pixel content table.
        cur_i = -1;
        cur_p = 2'd0;
        base  = 0;
        for (int k = 0; k < 36; k++) begin
            if (vecs[k].inst != cur_i || vecs[k].pat != cur_p) begin
                cur_i = vecs[k].inst;
                cur_p = vecs[k].pat;
                run_frame(cur_i, cur_p, base);
            end
            chk($sformatf("vec%0d_i%0d_p%0d_idx%0d", k, cur_i, cur_p, vecs[k].idx),
                mem[cur_i][12'(base + vecs[k].idx)], vecs[k].want);
        end
        chk("b_href_line_pclks", last_run[1], 16);

        // Enable dropped during the first active line.
        base = nbytes[0];
        d0 = dones[0];
        pat_v[0] = 2'd0;
        en_v[0]  = 1'b1;
        n = 0;
        while (nbytes[0] == base && n < 200) begin
            tick(1);
            n++;
        end
        en_v[0] = 1'b0;
        wait_done(0, d0 + 1, "t4_done");
        chk("t4_frame_bytes", nbytes[0] - base, 8);
        tick(2);
        r0 = rises[0];
        v0 = vs_ticks[0];
        tick(60);
        chk("t4_idle_pclk_rises", rises[0] - r0, 0);
        chk("t4_idle_pclk_level", pclk_v[0], 0);
        chk("t4_no_new_vsync", vs_ticks[0] - v0, 0);

        // Reset pulse in the blank gap after line 0.
        base = nbytes[0];
        en_v[0] = 1'b1;
        n = 0;
        while (!((nbytes[0] - base >= 4) && (hr_v[0] == 1'b0)) && n < 400) begin
            tick(1);
            n++;
        end
        chk("t5_reached_hblank", (nbytes[0] - base >= 4) ? 1 : 0, 1);
        d0 = dones[0];
        rstn_v[0] = 1'b0;
        tick(1);
        chk("t5_rst_outputs", {pclk_v[0], vs_v[0], hr_v[0], data_v[0], fd_v[0]}, 0);
        chk("t5_rst_frame_cnt", fcnt_v[0], 0);
        rstn_v[0] = 1'b1;
        en_v[0]   = 1'b0;
        tick(80);
        chk("t5_no_partial_done", dones[0] - d0, 0);
        v0 = vs_ticks[0];
        run_frame(0, 2'd0, base);
        chk("t5_first_byte", mem[0][12'(base)], 8'h00);
        chk("t5_vsync_pclks", vs_ticks[0] - v0, 3);
        chk("t5_frame_cnt", fcnt_v[0], 1);

        for (int i = 0; i < 3; i++)
            chk($sformatf("stable_at_pclk_rise_i%0d", i), viol[i], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_frame_gen.md
Name: dvp_frame_gen

Overview:
Synthesizable DVP transmitter that emulates the camera side of the parallel DVP interface: PCLK, VSYNC, HREF and 8-bit data.
- Drives cam_capture and the full capture → ft_ctrl → FT_Sync path without a sensor, in simulation and on the board via a loopback header.
- Frame geometry and byte format match the capture path: grayscale is 1 byte/pixel; RGB565 is 2 bytes/pixel, high byte first.

Parameters:
IM_X, 1280, active pixels per line
IM_Y, 720, active lines per frame
COLOR_MODE, 2, 1 = 1 byte/pixel gray, 2 = 2 bytes/pixel RGB565
H_BLANK, 64, blank PCLK periods after each active line (min 1)
VS_LEN, 16, PCLK periods VSYNC is high (min 1)
V_BACK, 32, PCLK periods from VSYNC fall to first HREF (min 1)
V_FRONT, 32, PCLK periods after last line before next VSYNC (min 1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  run request; sampled only at frame boundaries
pattern  in  2  0 = byte counter, 1 = colour bars, 2 = horizontal ramp, 3 = same as 0
PCLK_cam  out  1  generated pixel clock, clk/2
VSYNC_cam  out  1  frame sync, active high
HREF_cam  out  1  line valid, active high
data_cam  out  8  pixel byte
frame_done  out  1  one-clk pulse at end of V_FRONT
frame_cnt  out  16  completed frames, wraps at 16'hFFFF → 0

Behaviour:
- Reset: every output is 0. State is IDLE, and all counters and the pattern latch are cleared. Reset asserted mid-frame aborts the frame at the next edge; no partial frame_done is produced.
- PCLK generation:
  - In IDLE, PCLK_cam is held 0.
  - Otherwise PCLK_cam toggles every clk.
  - "tick" is a clk cycle in which PCLK_cam == 1, i.e. PCLK is about to fall.
  - VSYNC_cam, HREF_cam and data_cam update only on ticks, so they are stable for a full clk before and after each PCLK rising edge.
- All durations below are counted in ticks (PCLK periods).
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
  - IDLE → VSYNC: when enable == 1. PCLK starts toggling in the next cycle; VSYNC_cam rises on the first tick. pattern is latched here.
  - VSYNC: VSYNC_cam = 1 for VS_LEN ticks → VBACK.
  - VBACK: all low for V_BACK ticks → ACTIVE, with x = 0, y = 0.
  - ACTIVE: HREF_cam = 1 for IM_X*COLOR_MODE ticks, one byte per tick → HBLANK.
  - HBLANK: HREF_cam = 0 and data_cam = 0 for H_BLANK ticks. Then y++; → ACTIVE if y < IM_Y, else → VFRONT.
  - VFRONT: V_FRONT ticks. On the last tick, frame_done pulses and frame_cnt++. Then → VSYNC if enable == 1, else → IDLE (PCLK_cam parks at 0).
- enable deasserting mid-frame does not truncate the frame; the frame always completes.
- Byte index b counts 0..COLOR_MODE−1 within a pixel; x increments after the last byte of each pixel.
- Pattern 0 (byte counter):
  - data_cam = 8-bit counter, incremented per active byte.
  - Reset to 0 at each VSYNC entry; wraps 8'hFF → 8'h00.
  - Continues across lines within the frame.
- Pattern 1 (colour bars): 8 vertical bars, each IM_X/8 pixels wide; bar index = x / (IM_X/8), saturated at 7.
  - RGB565 values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Gray mode uses bytes FF, E0, C0, A0, 80, 60, 20, 00.
- Pattern 2 (ramp): v = x[7:0]. Gray mode outputs v; RGB565 outputs {v[7:3], v[7:2], v[7:3]}.
- Width rules: x, y and the tick counters are sized as $clog2 of their maximum + 1; there is no overflow at the maximum parameter values.
- Total frame length is VS_LEN + V_BACK + IM_Y*(IM_X*COLOR_MODE + H_BLANK) + V_FRONT ticks, i.e. twice that in clk cycles.

Decomposition:
- Shared package dvp_pkg holds:
  - state enum;
  - PAT_COUNTER/PAT_BARS/PAT_RAMP constants;
  - the 8-entry RGB565 and gray bar tables.
- One sub-module, dvp_pattern_rom: combinational (pattern, x, b, counter) → byte, so generator timing and pixel content verify independently.

Test Plan:
1. IM_X=4, IM_Y=2, COLOR_MODE=1, H_BLANK=2, VS_LEN=3, V_BACK=2, V_FRONT=2, pattern=0, enable=1 → VSYNC high for 3 PCLK; line 0 data 00,01,02,03; line 1 data 04..07; frame_done once per 19 PCLK (38 clk); frame_cnt 1, 2, 3.
2. IM_X=8, COLOR_MODE=2, pattern=1 → first line bytes FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00; HREF high for exactly 16 PCLK.
3. COLOR_MODE=1, IM_X=300, pattern=2 → data at x=255 is FF, at x=256 is 00, at x=299 is 2B.
4. Drop enable during ACTIVE of line 0 → frame completes, frame_done pulses, then IDLE with PCLK_cam=0; no further VSYNC.
5. Assert rst_n=0 for 1 clk mid-HBLANK → next cycle all outputs 0 and frame_cnt=0; re-enable gives a clean frame starting at VSYNC.
6. Checker on all frames → VSYNC_cam/HREF_cam/data_cam never change in a cycle where PCLK_cam rises; cam_capture connected end-to-end receives IM_X*IM_Y*COLOR_MODE bytes per frame.
